// File: rtl/pause_dim_ctrl_pkg.sv
// Shared state encoding and channel-dimming helper for the pause/dim controller.
// Pure declarations; no timing of its own.
package pause_dim_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        FADE,
        DIMMED
    } pause_st_t;

    localparam int CHAN_MAX_W = 16;

    function automatic logic [CHAN_MAX_W-1:0] dim_shift(input logic [CHAN_MAX_W-1:0] chan,
                                                        input int unsigned             lvl);
        return chan >> lvl;
    endfunction

endpackage

// File: rtl/pause_dim_ctrl_if.sv
// Video pixel bus: packed {R,G,B} pixel plus {hs,vs,hbl,vbl} sync.
// Free-running stream with one beat per clock and no backpressure.
interface pause_dim_ctrl_if #(
    parameter int RGB_W = 4
) ();
    logic [3*RGB_W-1:0] rgb;
    logic [3:0]         sync;

    modport master (output rgb, output sync);
    modport slave  (input  rgb, input  sync);
endinterface

// File: rtl/pause_dim_ctrl_rgb_dimmer.sv
// Registered per-channel right-shift dimmer with a matching sync delay.
// rgb and sync both lag their inputs by exactly one cycle; no backpressure.
module pause_dim_ctrl_rgb_dimmer
    import pause_dim_ctrl_pkg::*;
#(
    parameter int RGB_W = 4,
    parameter int LVL_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LVL_W-1:0]   lvl_i,
    input  logic [3*RGB_W-1:0] rgb_i,
    input  logic [3:0]         sync_i,
    output logic [3*RGB_W-1:0] rgb_o,
    output logic [3:0]         sync_o
);

    logic [3*RGB_W-1:0] rgb_d, rgb_q;
    logic [3:0]         sync_q;

    always_comb begin
        rgb_d = '0;
        for (int c = 0; c < 3; c++) begin
            rgb_d[c*RGB_W +: RGB_W] =
                RGB_W'(dim_shift(CHAN_MAX_W'(rgb_i[c*RGB_W +: RGB_W]), 32'(lvl_i)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q  <= '0;
            sync_q <= '0;
        end else begin
            rgb_q  <= rgb_d;
            sync_q <= sync_i;
        end
    end

    assign rgb_o  = rgb_q;
    assign sync_o = sync_q;

endmodule

// File: rtl/pause_dim_ctrl.sv
// Pause arbiter plus user-pause aging FSM driving a video dimmer; PAUSE_FADE_EN enables the multi-step fade.
// pause_out and video outputs lag their inputs by one cycle; no backpressure on the video stream.
module pause_dim_ctrl
    import pause_dim_ctrl_pkg::*;
#(
    parameter int          SRC_N         = 4,
    parameter int          RGB_W         = 4,
    parameter int          TIMER_W       = 32,
    parameter int unsigned DIM_CYCLES    = 480_000_000,
    parameter int unsigned FADE_STEP     = 4_800_000,
    parameter int          DIM_MAX_SHIFT = 2,
    localparam int         LVL_W         = $clog2(DIM_MAX_SHIFT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              user_btn_i,
    input  logic [SRC_N-1:0]  src_req_i,
    input  logic [SRC_N-1:0]  src_mask_i,
    pause_dim_ctrl_if.slave   vid_in,
    pause_dim_ctrl_if.master  vid_out,
    output logic              pause_out_o,
    output logic              user_paused_o,
    output logic [LVL_W-1:0]  dim_level_o
);

    localparam logic [TIMER_W-1:0] DIM_LAST = TIMER_W'(DIM_CYCLES - 1);
    localparam logic [LVL_W-1:0]   LVL_ONE  = LVL_W'(1);

`ifdef PAUSE_FADE_EN
    localparam int                 STEP_W    = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(FADE_STEP - 1);
    localparam logic [LVL_W-1:0]   LVL_MAX   = LVL_W'(DIM_MAX_SHIFT);
    logic [STEP_W-1:0]             step_q, step_d;
`else
    localparam int unsigned        unused_fade_step = FADE_STEP;
`endif

    logic               btn_s1_q, btn_s2_q, btn_prev_q, btn_edge;
    logic               toggle_q, toggle_d, pause_q;
    pause_st_t          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [3*RGB_W-1:0] dim_rgb;
    logic [3:0]         dim_sync;

    assign btn_edge = btn_s2_q & ~btn_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            toggle_q   <= 1'b0;
            pause_q    <= 1'b0;
            state_q    <= RUN;
            timer_q    <= '0;
            level_q    <= '0;
`ifdef PAUSE_FADE_EN
            step_q     <= '0;
`endif
        end else begin
            btn_s1_q   <= user_btn_i;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            toggle_q   <= toggle_d;
            pause_q    <= toggle_q | (|(src_req_i & src_mask_i));
            state_q    <= state_d;
            timer_q    <= timer_d;
            level_q    <= level_d;
`ifdef PAUSE_FADE_EN
            step_q     <= step_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        level_d  = level_q;
        toggle_d = toggle_q ^ btn_edge;
`ifdef PAUSE_FADE_EN
        step_d   = step_q;
`endif
        case (state_q)
            RUN: begin
                timer_d = '0;
                level_d = '0;
`ifdef PAUSE_FADE_EN
                step_d  = '0;
`endif
                if (btn_edge) state_d = HOLD;
            end
            HOLD: begin
                if (timer_q == DIM_LAST) begin
                    level_d = LVL_ONE;
`ifdef PAUSE_FADE_EN
                    state_d = (LVL_ONE == LVL_MAX) ? DIMMED : FADE;
`else
                    state_d = DIMMED;
`endif
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`ifdef PAUSE_FADE_EN
            FADE: begin
                if (step_q == STEP_LAST) begin
                    step_d  = '0;
                    level_d = level_q + 1'b1;
                    if (level_d == LVL_MAX) state_d = DIMMED;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
`endif
            default: ;
        endcase
        // A button edge outranks any same-cycle timer or fade advance.
        if (btn_edge && state_q != RUN) begin
            state_d = RUN;
            timer_d = '0;
            level_d = '0;
`ifdef PAUSE_FADE_EN
            step_d  = '0;
`endif
        end
    end

    pause_dim_ctrl_rgb_dimmer #(
        .RGB_W (RGB_W),
        .LVL_W (LVL_W)
    ) u_dimmer (
        .clk    (clk),
        .reset  (reset),
        .lvl_i  (level_q),
        .rgb_i  (vid_in.rgb),
        .sync_i (vid_in.sync),
        .rgb_o  (dim_rgb),
        .sync_o (dim_sync)
    );

    assign vid_out.rgb   = dim_rgb;
    assign vid_out.sync  = dim_sync;
    assign pause_out_o   = pause_q;
    assign user_paused_o = toggle_q;
    assign dim_level_o   = level_q;

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Randomized scoreboard bench for pause_dim_ctrl: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares; the reference model works from elapsed pause time.
module tb_pause_dim_ctrl;

    localparam int RGB_W = 4;
    localparam int D     = 100;
    localparam int FS    = 10;
    localparam int MAXS  = 2;
`ifdef PAUSE_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif
    localparam int EXP_TOP = FADE ? MAXS : 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       user_btn = 1'b0;
    logic [3:0] src_req = '0;
    logic [3:0] src_mask = '0;
    logic       pause_out, user_paused;
    logic [1:0] dim_level;

    pause_dim_ctrl_if #(.RGB_W(RGB_W)) vin ();
    pause_dim_ctrl_if #(.RGB_W(RGB_W)) vout ();

    pause_dim_ctrl #(
        .SRC_N         (4),
        .RGB_W         (RGB_W),
        .TIMER_W       (32),
        .DIM_CYCLES    (D),
        .FADE_STEP     (FS),
        .DIM_MAX_SHIFT (MAXS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .user_btn_i    (user_btn),
        .src_req_i     (src_req),
        .src_mask_i    (src_mask),
        .vid_in        (vin),
        .vid_out       (vout),
        .pause_out_o   (pause_out),
        .user_paused_o (user_paused),
        .dim_level_o   (dim_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tag;
        int rgb;
        int sync;
        int pause;
        int upaused;
        int lvl;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   in_rst   = 1'b1;
    int   max_lvl  = 0;

    // Reference model state: pause flag, cycle the pause began, last level, button history.
    bit m_paused;
    int m_start;
    int m_lvl;
    bit bh[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic int level_at(input int k);
        int el;
        int lv;
        if (!m_paused) return 0;
        el = k - m_start;
        if (el < D) return 0;
        if (!FADE) return 1;
        lv = 1 + (el - D) / FS;
        return (lv > MAXS) ? MAXS : lv;
    endfunction

    function automatic int dim_px(input int px, input int lvl);
        int r;
        r = 0;
        for (int c = 0; c < 3; c++) r += (((px >> (4 * c)) & 15) >> lvl) << (4 * c);
        return r;
    endfunction

    task automatic model_reset();
        m_paused = 1'b0;
        m_start  = 0;
        m_lvl    = 0;
        bh       = '{1'b0, 1'b0, 1'b0};
    endtask

    // Drive the inputs for the next rising edge and queue what that edge must produce.
    task automatic drive_cycle(input bit btn, input logic [3:0] req, input logic [3:0] mask,
                               input logic [11:0] px, input logic [3:0] sy);
        exp_t e;
        int   k;
        k = cyc + 1;
        user_btn = btn;
        src_req  = req;
        src_mask = mask;
        vin.rgb  = px;
        vin.sync = sy;
        e.tag   = k;
        e.rgb   = dim_px(int'(px), m_lvl);
        e.sync  = int'(sy);
        e.pause = int'(m_paused || ((req & mask) != 4'b0000));
        if (bh[1] && !bh[2]) begin
            m_paused = !m_paused;
            m_start  = k;
        end
        m_lvl = level_at(k);
        bh[2] = bh[1];
        bh[1] = bh[0];
        bh[0] = btn;
        e.upaused = int'(m_paused);
        e.lvl     = m_lvl;
        q.push_back(e);
    endtask

    task automatic tick(input bit btn, input logic [3:0] req, input logic [3:0] mask, input bit white);
        logic [11:0] px;
        logic [3:0]  sy;
        px = white ? 12'hFFF : 12'($urandom);
        sy = 4'($urandom);
        @(negedge clk);
        drive_cycle(btn, req, mask, px, sy);
    endtask

    task automatic tick_rand(input bit btn);
        tick(btn, 4'($urandom), 4'($urandom), 1'b0);
    endtask

    task automatic press();
        tick(1'b1, 4'b0000, 4'b0000, 1'b1);
        tick(1'b1, 4'b0000, 4'b0000, 1'b1);
        tick(1'b0, 4'b0000, 4'b0000, 1'b1);
    endtask

    // Time a press so the toggle lands exactly on rising edge t.
    task automatic press_at(input int t);
        while (cyc + 2 < t - 2) tick(1'b0, 4'b0000, 4'b0000, 1'b1);
        press();
    endtask

    task automatic reset_phase(input int n);
        if (!reset) begin
            @(negedge clk);
            #1;
            reset = 1'b1;
        end
        in_rst = 1'b1;
        q.delete();
        repeat (n) begin
            @(negedge clk);
            vin.rgb  = 12'($urandom);
            vin.sync = 4'($urandom);
            user_btn = 1'($urandom);
            chk("rst_pause_out",   32'(pause_out),   0);
            chk("rst_user_paused", 32'(user_paused), 0);
            chk("rst_dim_level",   32'(dim_level),   0);
            chk("rst_rgb_out",     32'(vout.rgb),    0);
            chk("rst_sync_out",    32'(vout.sync),   0);
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        in_rst = 1'b0;
        drive_cycle(1'b0, 4'b0000, 4'b0000, 12'($urandom), 4'($urandom));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!in_rst) begin
                while (q.size() > 0 && q[0].tag <= cyc) begin
                    e = q.pop_front();
                    chk($sformatf("rgb_out@%0d", e.tag),     32'(vout.rgb),    e.rgb);
                    chk($sformatf("sync_out@%0d", e.tag),    32'(vout.sync),   e.sync);
                    chk($sformatf("pause_out@%0d", e.tag),   32'(pause_out),   e.pause);
                    chk($sformatf("user_paused@%0d", e.tag), 32'(user_paused), e.upaused);
                    chk($sformatf("dim_level@%0d", e.tag),   32'(dim_level),   e.lvl);
                end
                if (int'(dim_level) > max_lvl) max_lvl = int'(dim_level);
            end
        end
    end

    initial begin
        vin.rgb  = '0;
        vin.sync = '0;
        model_reset();
        reset_phase(3);
        repeat (30) tick_rand(1'b0);
        reset_phase(3);

        // External sources: pause only, never age or dim.
        repeat (5)    tick(1'b0, 4'b0010, 4'b0010, 1'b0);
        repeat (5)    tick(1'b0, 4'b0010, 4'b0000, 1'b0);
        repeat (1000) tick(1'b0, 4'b0010, 4'b0010, 1'b1);
        repeat (200)  tick_rand(1'b0);

        // User pause ages into dimming, then holds.
        max_lvl = 0;
        press();
        repeat (D + 3 * FS) tick(1'b0, 4'b0000, 4'b0000, 1'b1);
        repeat (500) tick_rand(1'b0);
        chk("max_dim_level", 32'(max_lvl), EXP_TOP);

        press();
        repeat (20) tick_rand(1'b0);
        press();
        press_at(m_start + D);
        repeat (20) tick_rand(1'b0);
        press();
        press_at(m_start + D + (FADE ? FS : 5));
        repeat (20) tick_rand(1'b0);
        press();
        repeat (D + 10) tick(1'b0, 4'b0000, 4'b0000, 1'b1);
        press();
        repeat (10) tick_rand(1'b0);

        repeat (2000) tick_rand($urandom_range(0, 149) == 0);
        repeat (5) tick_rand(1'b0);
        if (m_paused) press();

        press();
        repeat (D + 5) tick(1'b0, 4'b0000, 4'b0000, 1'b1);
        reset_phase(2);
        repeat (20) tick_rand(1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
